axis_matmul_nxn: RTL

Parametrised AXI4-Stream matrix-multiply engine, the N×N successor of the fixed 2×2 stream wrapper. It accumulates an outer product per input beat into an N×N accumulator array until `s_axis_tlast`. It then drains the result matrix row by row on the master stream with correct `tlast` framing and full back-pressure support. It sits between the DMA input stream and the result stream, in the same slot as the 2×2 block.

---
 rtl/axis_matmul_pkg.sv | 29 ++
 rtl/matmul_mac_cell.sv | 32 +++
 rtl/axis_matmul_nxn.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/axis_matmul_pkg.sv
// Shared types, default bus geometry and lane-offset helpers for the AXI4-Stream N x N matrix-multiply engine.
package axis_matmul_pkg;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam int DEF_N     = 2;
    localparam int DEF_DW    = 4;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_S_W   = 2 * DEF_N * DEF_DW;
    localparam int DEF_M_W   = DEF_N * DEF_ACC_W;

    // LSB of a_i inside the input beat (A column lanes come first)
    function automatic int a_lsb(input int i, input int dw);
        return i * dw;
    endfunction

    // LSB of b_j inside the input beat (B row lanes follow the N A lanes)
    function automatic int b_lsb(input int j, input int n, input int dw);
        return (n + j) * dw;
    endfunction

    function automatic int c_lsb(input int j, input int acc_w);
        return j * acc_w;
    endfunction

endpackage

// File: rtl/matmul_mac_cell.sv
// One wrapping accumulator element c[i][j] with synchronous clear and accumulate enable.
module matmul_mac_cell
    import axis_matmul_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] prod,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] acc_r;

    // Accumulator register; clear wins over accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + prod;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/axis_matmul_nxn.sv
// AXI4-Stream N x N outer-product accumulator; drains C row by row after s_axis_tlast.
// Build option: define AXIS_MATMUL_SIGNED_EN for two's-complement operands.
module axis_matmul_nxn
    import axis_matmul_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_axis_tvalid,
    input  logic [2*N*DW-1:0]    s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic                 m_axis_tvalid,
    output logic [N*ACC_W-1:0]   m_axis_tdata,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready
);

    localparam int M_W = N * ACC_W;
    localparam int RW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

    state_t           state_r, state_nxt_s;
    logic [RW-1:0]    row_r, row_nxt_s;
    logic             s_ready_r, m_valid_r, m_last_r;
    logic             s_hs_s, m_hs_s, clr_s, en_s;
    logic [ACC_W-1:0] a_ext_s [N];
    logic [ACC_W-1:0] b_ext_s [N];
    logic [ACC_W-1:0] acc_s   [N][N];
    logic [M_W-1:0]   row_data_s;

    assign s_hs_s = s_axis_tvalid && s_ready_r;
    assign m_hs_s = m_valid_r && m_axis_tready;

    // Operand widening: sign- or zero-extend so the ACC_W product wraps correctly
    for (genvar k = 0; k < N; k++) begin : g_ext
`ifdef AXIS_MATMUL_SIGNED_EN
        assign a_ext_s[k] = ACC_W'($signed(s_axis_tdata[a_lsb(k, DW) +: DW]));
        assign b_ext_s[k] = ACC_W'($signed(s_axis_tdata[b_lsb(k, N, DW) +: DW]));
`else
        assign a_ext_s[k] = ACC_W'(s_axis_tdata[a_lsb(k, DW) +: DW]);
        assign b_ext_s[k] = ACC_W'(s_axis_tdata[b_lsb(k, N, DW) +: DW]);
`endif
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [ACC_W-1:0] prod_s;
            assign prod_s = a_ext_s[i] * b_ext_s[j];

            matmul_mac_cell #(.ACC_W(ACC_W)) u_cell (
                .clk  (clk),
                .rst  (rst),
                .clr  (clr_s),
                .en   (en_s),
                .prod (prod_s),
                .acc  (acc_s[i][j])
            );
        end
    end

    // Next-state, row counter and accumulator control
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        clr_s       = 1'b0;
        en_s        = 1'b0;
        case (state_r)
            ST_ACCUM: begin
                if (s_hs_s) begin
                    en_s = 1'b1;
                    if (s_axis_tlast) begin
                        state_nxt_s = ST_DRAIN;
                        row_nxt_s   = {RW{1'b0}};
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    en_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (m_hs_s) begin
                    if (row_r == ROW_LAST) begin
                        clr_s       = 1'b1;
                        row_nxt_s   = {RW{1'b0}};
                        state_nxt_s = ST_ACCUM;
                    end else begin
                        row_nxt_s = row_r + {{(RW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    row_nxt_s = row_r;
                end
            end
            default: begin
                state_nxt_s = ST_ACCUM;
                row_nxt_s   = {RW{1'b0}};
            end
        endcase
    end

    // State register with handshake flags registered off the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_ACCUM;
            row_r     <= {RW{1'b0}};
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            row_r     <= row_nxt_s;
            s_ready_r <= (state_nxt_s == ST_ACCUM);
            m_valid_r <= (state_nxt_s == ST_DRAIN);
            m_last_r  <= (state_nxt_s == ST_DRAIN) && (row_nxt_s == ROW_LAST);
        end
    end

    // Row select from the accumulator array
    always_comb begin
        row_data_s = {M_W{1'b0}};
        for (int r = 0; r < N; r++) begin
            if (row_r == RW'(r)) begin
                for (int j = 0; j < N; j++) begin
                    row_data_s[c_lsb(j, ACC_W) +: ACC_W] = acc_s[r][j];
                end
            end else begin
                row_data_s = row_data_s;
            end
        end
    end

    assign s_axis_tready = s_ready_r;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tlast  = m_last_r;
    assign m_axis_tdata  = m_valid_r ? row_data_s : {M_W{1'b0}};

endmodule
